// File: rtl/fb_scan_ctrl.sv
// Framebuffer scanout fetcher: prefetches display lines from word memory into a
// two-bank line buffer, driven by blanking edges from the sync generator.
module fb_scan_ctrl #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int FB_BASE = 0,
  parameter int ADDR_W  = 20,
  parameter int MAX_OUT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hblank,
  input  logic              i_vblank,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_gnt,
  input  logic              i_rd_valid,
  input  logic [31:0]       i_rd_data,
  output logic              o_lb_we,
  output logic [9:0]        o_lb_waddr,
  output logic [31:0]       o_lb_wdata,
  output logic              o_lb_rsel,
  output logic              o_busy,
  output logic              o_underrun,
  input  logic              i_underrun_clr
);
  localparam int WPL = H_ACT / 2;
  localparam int CW  = $clog2(WPL + 1);
  localparam int LW  = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  localparam logic [CW-1:0]     WPL_C     = CW'(WPL);
  localparam logic [LW-1:0]     LAST_LINE = LW'(V_ACT - 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] WPL_A     = ADDR_W'(WPL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              hblank_q, hblank_d, vblank_q, vblank_d;
  logic              frame_seen_q, frame_seen_d;
  logic [LW-1:0]     disp_line_q, disp_line_d;
  logic [LW-1:0]     fetch_line_q, fetch_line_d;
  logic              pending_q, pending_d;
  logic [CW-1:0]     issued_q, issued_d, received_q, received_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              lb_we_q, lb_we_d;
  logic [9:0]        lb_waddr_q, lb_waddr_d;
  logic [31:0]       lb_wdata_q, lb_wdata_d;
  logic              underrun_q, underrun_d;

  logic          hb_rise, vb_rise, rd_req, underrun_set, do_start;
  logic [LW-1:0] start_line;
  logic [CW-1:0] outstanding;

  always_comb begin
    state_d      = state_q;
    hblank_d     = i_hblank;
    vblank_d     = i_vblank;
    frame_seen_d = frame_seen_q;
    disp_line_d  = disp_line_q;
    fetch_line_d = fetch_line_q;
    pending_d    = pending_q;
    issued_d     = issued_q;
    received_d   = received_q;
    addr_d       = addr_q;
    lb_we_d      = 1'b0;
    lb_waddr_d   = lb_waddr_q;
    lb_wdata_d   = lb_wdata_q;
    underrun_set = 1'b0;
    do_start     = 1'b0;
    start_line   = '0;

    hb_rise     = i_hblank & ~hblank_q;
    vb_rise     = i_vblank & ~vblank_q;
    outstanding = issued_q - received_q;
    rd_req      = (state_q == S_FETCH) && (issued_q < WPL_C) &&
                  (32'(outstanding) < 32'(MAX_OUT));

    if (rd_req && i_rd_gnt) begin
      issued_d = issued_q + CW'(1);
      addr_d   = addr_q + ADDR_W'(1);
    end

    // Returns are always counted so ABORT can tell when memory has gone quiet.
    if (i_rd_valid && (outstanding != '0) && (state_q != S_IDLE)) begin
      received_d = received_q + CW'(1);
      if (state_q != S_ABORT) begin
        lb_we_d    = 1'b1;
        lb_waddr_d = {fetch_line_q[0], 9'(received_q)};
        lb_wdata_d = i_rd_data;
      end
    end

    case (state_q)
      S_FETCH: if (issued_q == WPL_C) state_d = S_DRAIN;
      S_DRAIN: begin
        if (received_q == WPL_C) begin
          if (pending_q) begin
            do_start   = 1'b1;
            start_line = LW'(1);
            pending_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ABORT: begin
        if (outstanding == '0) begin
          do_start   = 1'b1;
          start_line = '0;
          pending_d  = 1'b1;
        end
      end
      default: begin
        if (pending_q) begin
          do_start   = 1'b1;
          start_line = LW'(1);
          pending_d  = 1'b0;
        end
      end
    endcase

    if (vb_rise) begin
      disp_line_d  = '0;
      frame_seen_d = 1'b1;
      if (state_q == S_IDLE) begin
        do_start   = 1'b1;
        start_line = '0;
        pending_d  = 1'b1;
      end else begin
        underrun_set = 1'b1;
        do_start     = 1'b0;
        pending_d    = 1'b0;
        state_d      = S_ABORT;
      end
    end else if (hb_rise && !i_vblank) begin
      if (disp_line_q != LAST_LINE) disp_line_d = disp_line_q + LW'(1);
      // Line n just finished, so its bank is free for line n+2.
      if (frame_seen_q && (32'(disp_line_q) + 32'd2 < 32'(V_ACT))) begin
        if (state_q == S_IDLE) begin
          do_start   = 1'b1;
          start_line = disp_line_q + LW'(2);
        end else begin
          underrun_set = 1'b1;
        end
      end
    end

    if (do_start) begin
      state_d      = S_FETCH;
      fetch_line_d = start_line;
      issued_d     = '0;
      received_d   = '0;
      addr_d       = BASE_A + ADDR_W'(start_line) * WPL_A;
    end

    underrun_d = underrun_set | (underrun_q & ~i_underrun_clr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      hblank_q     <= 1'b0;
      vblank_q     <= 1'b0;
      frame_seen_q <= 1'b0;
      disp_line_q  <= '0;
      fetch_line_q <= '0;
      pending_q    <= 1'b0;
      issued_q     <= '0;
      received_q   <= '0;
      addr_q       <= '0;
      lb_we_q      <= 1'b0;
      lb_waddr_q   <= '0;
      lb_wdata_q   <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hblank_q     <= hblank_d;
      vblank_q     <= vblank_d;
      frame_seen_q <= frame_seen_d;
      disp_line_q  <= disp_line_d;
      fetch_line_q <= fetch_line_d;
      pending_q    <= pending_d;
      issued_q     <= issued_d;
      received_q   <= received_d;
      addr_q       <= addr_d;
      lb_we_q      <= lb_we_d;
      lb_waddr_q   <= lb_waddr_d;
      lb_wdata_q   <= lb_wdata_d;
      underrun_q   <= underrun_d;
    end
  end

  assign o_rd_req   = rd_req;
  assign o_rd_addr  = addr_q;
  assign o_lb_we    = lb_we_q;
  assign o_lb_waddr = lb_waddr_q;
  assign o_lb_wdata = lb_wdata_q;
  assign o_lb_rsel  = disp_line_q[0];
  assign o_busy     = (state_q != S_IDLE);
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// Randomized scoreboard bench for fb_scan_ctrl: memory model with random grant
// and latency, expected line-buffer writes derived from the line/address rules.
module tb_fb_scan_ctrl;
  localparam int H_ACT   = 8;
  localparam int V_ACT   = 4;
  localparam int FB_BASE = 'h120;
  localparam int ADDR_W  = 20;
  localparam int MAX_OUT = 2;
  localparam int WPL     = H_ACT / 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hblank = 1'b0, vblank = 1'b0;
  logic              rd_gnt = 1'b0, rd_valid = 1'b0, underrun_clr = 1'b0;
  logic [31:0]       rd_data = '0;
  logic              rd_req, lb_we, lb_rsel, busy, underrun;
  logic [ADDR_W-1:0] rd_addr;
  logic [9:0]        lb_waddr;
  logic [31:0]       lb_wdata;

  fb_scan_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .FB_BASE(FB_BASE), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hblank(hblank), .i_vblank(vblank),
    .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_gnt(rd_gnt),
    .i_rd_valid(rd_valid), .i_rd_data(rd_data),
    .o_lb_we(lb_we), .o_lb_waddr(lb_waddr), .o_lb_wdata(lb_wdata),
    .o_lb_rsel(lb_rsel), .o_busy(busy), .o_underrun(underrun),
    .i_underrun_clr(underrun_clr)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [9:0] waddr; logic [31:0] wdata; } wr_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } rd_t;

  wr_t               exp_wr_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  rd_t               mem_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit stall = 1'b0, hold = 1'b0;
  int m_disp = 0;
  bit m_started = 1'b0, m_underrun = 1'b0;

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return ({12'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sched_line(input int l);
    for (int w = 0; w < WPL; w++) begin
      logic [ADDR_W-1:0] a;
      wr_t e;
      a = ADDR_W'(FB_BASE + l * WPL + w);
      e.waddr = {1'(l % 2), 9'(w)};
      e.wdata = word_of(a);
      exp_wr_q.push_back(e);
      exp_addr_q.push_back(a);
    end
  endtask

  task automatic do_vblank();
    if (exp_wr_q.size() != 0) begin
      m_underrun = 1'b1;
      exp_wr_q.delete();
      exp_addr_q.delete();
    end
    m_disp = 0;
    m_started = 1'b1;
    sched_line(0);
    sched_line(1);
    vblank = 1'b1;
  endtask

  task automatic do_hblank();
    if (m_started && (m_disp + 2 < V_ACT)) begin
      if (exp_wr_q.size() != 0) m_underrun = 1'b1;
      else sched_line(m_disp + 2);
    end
    if (m_disp < V_ACT - 1) m_disp++;
    hblank = 1'b1;
    tick(2);
    hblank = 1'b0;
    tick(2);
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while ((exp_wr_q.size() != 0 || mem_q.size() != 0) && t < 3000) begin
      tick(1);
      t++;
    end
    check("drain_done", (t < 3000), 1);
    if (t >= 3000) begin
      exp_wr_q.delete();
      exp_addr_q.delete();
    end
    tick(3);
  endtask

  task automatic quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_underrun"}, underrun, m_underrun);
    check({tag, "_rsel"}, lb_rsel, m_disp & 1);
  endtask

  task automatic clear_underrun();
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    m_underrun = 1'b0;
    tick(1);
    check("underrun_clr", underrun, 0);
  endtask

  // Memory: records grants, returns words in order after random latency.
  initial begin : mem
    bit prev_req = 1'b0, prev_gnt = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    rd_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mem_q.delete();
        prev_req = 1'b0;
        prev_gnt = 1'b0;
        rd_gnt = 1'b0;
        rd_valid = 1'b0;
      end else begin
        if (prev_req && prev_gnt) begin
          if (exp_addr_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_addr: got request at %0h, expected no request", prev_addr);
          end else begin
            check("rd_addr", prev_addr, exp_addr_q.pop_front());
          end
          r.addr = prev_addr;
          r.due = cyc + int'($urandom_range(0, 2));
          mem_q.push_back(r);
        end
        if (prev_req && !prev_gnt) begin
          check("req_hold", rd_req, 1);
          check("addr_hold", rd_addr, prev_addr);
        end
        if (rd_req) check("max_out", (mem_q.size() < MAX_OUT), 1);
        prev_req = rd_req;
        prev_addr = rd_addr;
        rd_gnt = stall ? 1'b0 : (hold ? 1'b1 : ($urandom_range(0, 3) != 0));
        prev_gnt = rd_gnt;
        if (!hold && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
          r = mem_q.pop_front();
          rd_valid = 1'b1;
          rd_data = word_of(r.addr);
        end else begin
          rd_valid = !hold && (mem_q.size() == 0) && ($urandom_range(0, 7) == 0);
          rd_data = $urandom;
        end
      end
    end
  end

  initial begin : mon
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && lb_we) begin
        if (exp_wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL lb_write: got write %0h=%0h, expected no write", lb_waddr, lb_wdata);
        end else begin
          e = exp_wr_q.pop_front();
          check("lb_waddr", lb_waddr, e.waddr);
          check("lb_wdata", lb_wdata, e.wdata);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int kind;
    rst_n = 1'b0;
    tick(3);
    check("rst_rd_req", rd_req, 0);
    check("rst_lb_we", lb_we, 0);
    check("rst_lb_waddr", lb_waddr, 0);
    check("rst_lb_wdata", lb_wdata, 0);
    check("rst_rsel", lb_rsel, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    tick(2);

    do_hblank();
    do_hblank();
    tick(5);
    quiet("prevb");

    for (int f = 0; f < 12; f++) begin
      kind = (f < 3) ? f : int'($urandom_range(0, 2));
      do_vblank();
      tick(2);
      wait_empty();
      quiet("vb");
      vblank = 1'b0;
      tick(2);
      case (kind)
        0: begin
          for (int n = 0; n < V_ACT; n++) begin
            do_hblank();
            wait_empty();
            quiet("line");
          end
        end
        1: begin
          stall = 1'b1;
          tick(1);
          do_hblank();
          check("stall_req", rd_req, 1);
          check("stall_addr", rd_addr, FB_BASE + 2 * WPL);
          tick(5);
          do_hblank();
          check("underrun_set", underrun, 1);
          check("stall_busy", busy, 1);
          stall = 1'b0;
          wait_empty();
          quiet("ur");
          clear_underrun();
          do_hblank();
          wait_empty();
          quiet("l2");
          do_hblank();
          wait_empty();
          quiet("l3");
        end
        default: begin
          hold = 1'b1;
          tick(1);
          do_hblank();
          tick(10);
          check("maxout_req", rd_req, 0);
          check("maxout_cnt", mem_q.size(), MAX_OUT);
          do_vblank();
          tick(4);
          check("abort_busy", busy, 1);
          check("abort_req", rd_req, 0);
          check("abort_underrun", underrun, 1);
          hold = 1'b0;
          wait_empty();
          quiet("ab");
          clear_underrun();
          vblank = 1'b0;
          tick(2);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
